// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory test sequencer: FSM states,
// Avalon-MM widths and the address-derived data pattern.
package mem_test_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] DEFAULT_PATTERN_KEY = 32'hA5A5_A5A5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        FINISH  = 3'd4
    } seq_state_t;

    // Each word's data is its own byte address, zero-extended and XORed with the key.
    function automatic logic [DATA_W-1:0] word_pattern(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] key
    );
        return {{(DATA_W-ADDR_W){1'b0}}, addr} ^ key;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for an active-low board key plus a falling-edge
// detector; fall_pulse is high for one cycle per synchronized press.
module key_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_n,
    output logic fall_pulse
);

    logic sync_meta_reg;
    logic sync_reg;
    logic prev_reg;

    // All stages idle high so a key already held at reset release is not a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta_reg <= 1'b1;
            sync_reg      <= 1'b1;
            prev_reg      <= 1'b1;
        end else begin
            sync_meta_reg <= async_n;
            sync_reg      <= sync_meta_reg;
            prev_reg      <= sync_reg;
        end
    end

    assign fall_pulse = prev_reg & ~sync_reg;

endmodule

// File: rtl/mem_test_sequencer.sv
// Key-triggered memory tester: writes or reads/checks NUM_WORDS consecutive
// 32-bit words over Avalon-MM, counting read-back mismatches.
module mem_test_sequencer
    import mem_test_pkg::*;
#(
    parameter int                NUM_WORDS   = 256,
    parameter logic [DATA_W-1:0] PATTERN_KEY = DEFAULT_PATTERN_KEY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              n_action,
    input  logic              rdwr_cntl,
    input  logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);

    seq_state_t        state_reg;
    logic [15:0]       word_cnt_reg;
    logic              start_pulse;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] expected_data;
    logic              last_word;

    key_edge_sync u_key_edge_sync (
        .clock      (clock),
        .reset      (reset),
        .async_n    (n_action),
        .fall_pulse (start_pulse)
    );

    assign start_addr     = address & 26'h3FF_FFFC;
    assign next_addr      = avm_address + 26'd4;
    assign expected_data  = word_pattern(avm_address, PATTERN_KEY);
    assign last_word      = (word_cnt_reg == LAST_WORD);
    assign avm_byteenable = 4'hF;

    // avm_address doubles as the current word address; 26-bit adds wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            word_cnt_reg  <= 16'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error_count   <= 16'd0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_pulse) begin
                        busy         <= 1'b1;
                        word_cnt_reg <= 16'd0;
                        avm_address  <= start_addr;
                        if (rdwr_cntl) begin
                            state_reg   <= RD_REQ;
                            avm_read    <= 1'b1;
                            error_count <= 16'd0;
                        end else begin
                            state_reg     <= WR_REQ;
                            avm_write     <= 1'b1;
                            avm_writedata <= word_pattern(start_addr, PATTERN_KEY);
                        end
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        if (last_word) begin
                            avm_write <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            word_cnt_reg  <= word_cnt_reg + 16'd1;
                            avm_address   <= next_addr;
                            avm_writedata <= word_pattern(next_addr, PATTERN_KEY);
                        end
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        if (avm_readdata != expected_data && error_count != 16'hFFFF) begin
                            error_count <= error_count + 16'd1;
                        end
                        if (last_word) begin
                            done      <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 16'd1;
                            avm_address  <= next_addr;
                            avm_read     <= 1'b1;
                            state_reg    <= RD_REQ;
                        end
                    end
                end
                FINISH: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Scoreboard bench: expected Avalon transfers are queued per command and
// matched against the bus as a responder completes each one.
module tb_mem_test_sequencer;

    localparam int NW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        n_action = 1'b1;
    logic        rdwr_cntl = 1'b0;
    logic [25:0] address = '0;
    logic        busy;
    logic        done;
    logic [15:0] error_count;
    logic [25:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;

    mem_test_sequencer #(.NUM_WORDS(NW), .PATTERN_KEY(32'hA5A5_A5A5)) dut (
        .clock             (clock),
        .reset             (reset),
        .n_action          (n_action),
        .rdwr_cntl         (rdwr_cntl),
        .address           (address),
        .busy              (busy),
        .done              (done),
        .error_count       (error_count),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        is_read;
        logic [25:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] mem [logic [25:0]];
    int          checks = 0;
    int          errors = 0;
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    int          rd_delay = 0;
    logic        spurious_en = 1'b0;
    logic [25:0] held_addr = '0;
    logic [31:0] held_data = '0;
    logic [31:0] rd_data = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pattern(input logic [25:0] a);
        return {6'b0, a} ^ 32'hA5A5_A5A5;
    endfunction

    task automatic push_cmd(input logic rd, input logic [25:0] start);
        logic [25:0] a;
        for (int i = 0; i < NW; i++) begin
            a = start + 26'(4 * i);
            exp_q.push_back('{rd, a, model_pattern(a)});
        end
    endtask

    // Memory-side responder: programmable stall per request, fixed read latency.
    always @(negedge clock) begin
        xfer_t e;
        avm_readdatavalid = 1'b0;
        if (reset) begin
            stall_cnt = 0;
            rd_delay = 0;
            avm_waitrequest = 1'b0;
        end else begin
            check_val("rw_excl", 32'(avm_read & avm_write), 32'd0);
            if (!busy) check_val("idle_strobes", 32'({avm_read, avm_write}), 32'd0);
            if (rd_delay > 0) begin
                rd_delay--;
                if (rd_delay == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = rd_data;
                end
            end
            if (avm_read || avm_write) begin
                if (stall_cnt > 0) begin
                    check_val("stall_addr", 32'(avm_address), 32'(held_addr));
                    if (avm_write) check_val("stall_data", avm_writedata, held_data);
                end
                if (stall_cnt < stall_cfg) begin
                    if (stall_cnt == 0) begin
                        held_addr = avm_address;
                        held_data = avm_writedata;
                    end
                    avm_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                    if (exp_q.size() == 0) begin
                        check_val("sb_pending", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        $display("xfer %s addr=0x%07h data=0x%08h", avm_read ? "RD" : "WR",
                                 avm_address, avm_read ? (mem.exists(avm_address) ? mem[avm_address] : 32'd0) : avm_writedata);
                        check_val("xfer_kind", 32'(avm_read), 32'(e.is_read));
                        check_val("xfer_addr", 32'(avm_address), 32'(e.addr));
                        if (avm_write) begin
                            check_val("xfer_wdata", avm_writedata, e.data);
                            mem[avm_address] = avm_writedata;
                        end else begin
                            rd_data = mem.exists(avm_address) ? mem[avm_address] : 32'd0;
                            rd_delay = 2;
                        end
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt = 0;
            end
            if (spurious_en && avm_write && !avm_readdatavalid) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Press the key, check start latency, then wait for the one done pulse.
    task automatic run_cmd(input logic rd, input logic [25:0] addr, input int stall,
                           input logic [15:0] exp_err, input logic skip_push);
        int dones;
        int cycles;
        stall_cfg = stall;
        rdwr_cntl = rd;
        address = addr;
        if (!skip_push) push_cmd(rd, addr & 26'h3FF_FFFC);
        @(negedge clock);
        n_action = 1'b0;
        @(posedge clock); #1;
        check_val("busy_lat1", 32'(busy), 32'd0);
        @(posedge clock); #1;
        check_val("busy_lat2", 32'(busy), 32'd0);
        @(posedge clock); #1;
        check_val("busy_rise", 32'(busy), 32'd1);
        check_val("strobe_rise", 32'({avm_read, avm_write}), rd ? 32'd2 : 32'd1);
        n_action = 1'b1;
        dones = 0;
        cycles = 0;
        while (1) begin
            @(posedge clock); #1;
            if (done) dones++;
            if (!busy) break;
            cycles++;
            if (cycles > 400) begin
                check_val("cmd_timeout", 32'(cycles), 32'd400);
                break;
            end
        end
        repeat (3) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        check_val("done_pulses", 32'(dones), 32'd1);
        check_val("error_count", 32'(error_count), 32'(exp_err));
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("cmd %s start=0x%07h errors=%0d", rd ? "RD" : "WR", addr, error_count);
    endtask

    initial begin
        int cycles;
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(error_count), 32'd0);
        check_val("rst_strobes", 32'({avm_read, avm_write}), 32'd0);
        check_val("rst_addr", 32'(avm_address), 32'd0);
        check_val("rst_wdata", avm_writedata, 32'd0);
        check_val("byteenable", 32'(avm_byteenable), 32'hF);
        @(negedge clock);
        reset = 1'b0;

        // Write at 0x100: expected data taken from the literal reference values
        exp_q.push_back('{1'b0, 26'h100, 32'hA5A5_A4A5});
        exp_q.push_back('{1'b0, 26'h104, 32'hA5A5_A4A1});
        exp_q.push_back('{1'b0, 26'h108, 32'hA5A5_A4AD});
        exp_q.push_back('{1'b0, 26'h10C, 32'hA5A5_A4A9});
        run_cmd(1'b0, 26'h100, 0, 16'd0, 1'b1);

        // Read back with low address bits set (must be forced to 0)
        run_cmd(1'b1, 26'h103, 0, 16'd0, 1'b0);

        // Corrupt word 2, stall every request 3 cycles
        mem[26'h108] = mem[26'h108] ^ 32'h0000_0010;
        run_cmd(1'b1, 26'h100, 3, 16'd1, 1'b0);

        // Wrap-around write; stray readdatavalid during writes must not count
        spurious_en = 1'b1;
        run_cmd(1'b0, 26'h3FF_FFF8, 1, 16'd1, 1'b0);
        spurious_en = 1'b0;
        check_val("wrap_mem0", mem.exists(26'h0) ? mem[26'h0] : 32'd0, 32'hA5A5_A5A5);

        // Read of the wrapped region clears the previous error count
        run_cmd(1'b1, 26'h3FF_FFF8, 0, 16'd0, 1'b0);

        // Read with word 0 corrupted, second press while busy, then reset mid-read
        mem[26'h100] = mem[26'h100] ^ 32'h8000_0000;
        stall_cfg = 3;
        rdwr_cntl = 1'b1;
        address = 26'h100;
        push_cmd(1'b1, 26'h100);
        @(negedge clock);
        n_action = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_cmd_busy", 32'(busy), 32'd1);
        n_action = 1'b1;
        repeat (4) @(negedge clock);
        n_action = 1'b0;
        cycles = 0;
        while (!(exp_q.size() == 2 && avm_read)) begin
            @(posedge clock); #1;
            cycles++;
            if (cycles > 200) begin
                check_val("rst_cmd_timeout", 32'(cycles), 32'd200);
                break;
            end
        end
        check_val("err_before_rst", 32'(error_count), 32'd1);
        check_val("busy_before_rst", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_read", 32'(avm_read), 32'd0);
        check_val("async_rst_busy", 32'(busy), 32'd0);
        check_val("async_rst_err", 32'(error_count), 32'd0);
        check_val("async_rst_done", 32'(done), 32'd0);
        check_val("async_rst_addr", 32'(avm_address), 32'd0);
        exp_q.delete();
        n_action = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            check_val("no_done_after_rst", 32'({done, busy}), 32'd0);
        end

        // Fresh command after reset starts at word 0
        run_cmd(1'b0, 26'h200, 0, 16'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
